// File: rtl/reg_ex_mem.sv
// ---------------------------------------------------------------------------
// reg_ex_mem
//   EX/MEM pipeline register. Captures the execute-stage results (opcode,
//   instruction address, ALU result) and a valid bit on every rising edge of
//   clk. The memory stage sees them one cycle later. The register can hold its
//   contents (stall) or load a bubble (flush).
//
//   Ports
//     clk               system clock, all state changes on the rising edge
//     rst               synchronous reset, active-high
//     stall             hold the current contents
//     flush             load a bubble on the next edge (beats stall)
//     valid_in          EX-stage instruction is valid
//     OpCode            EX-stage opcode            [OPCODE_W-1:0]
//     CurrentAddress    EX-stage address           [ADDR_W-1:0]
//     ResultAlu         EX-stage ALU result        [DATA_W-1:0]
//     valid_out         registered valid bit
//     OpCodeOut         registered opcode          [OPCODE_W-1:0]
//     CurrentAddressOut registered address         [ADDR_W-1:0]
//     ResultAluOut      registered ALU result      [DATA_W-1:0]
//
//   Priority at each edge: rst > flush > stall > capture.
//   Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module reg_ex_mem #(
    parameter int                     OPCODE_W   = 5,
    parameter int                     ADDR_W     = 7,
    parameter int                     DATA_W     = 32,
    parameter logic [OPCODE_W-1:0]    NOP_OPCODE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [OPCODE_W-1:0] OpCode,
    input  logic [ADDR_W-1:0]   CurrentAddress,
    input  logic [DATA_W-1:0]   ResultAlu,
    output logic                valid_out,
    output logic [OPCODE_W-1:0] OpCodeOut,
    output logic [ADDR_W-1:0]   CurrentAddressOut,
    output logic [DATA_W-1:0]   ResultAluOut
);

    logic                vld_p1;
    logic [OPCODE_W-1:0] opcode_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   result_p1;

    // ---- EX -> MEM stage boundary -----------------------------------------
    // A bubble clears the data fields as well as the valid bit, so a flushed
    // slot is indistinguishable from a freshly reset one. valid_in=0 is a
    // normal capture: the data fields are still loaded.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1    <= 1'b0;
            opcode_p1 <= NOP_OPCODE;
            addr_p1   <= '0;
            result_p1 <= '0;
        end else if (!stall) begin
            vld_p1    <= valid_in;
            opcode_p1 <= OpCode;
            addr_p1   <= CurrentAddress;
            result_p1 <= ResultAlu;
        end
    end

    assign valid_out         = vld_p1;
    assign OpCodeOut         = opcode_p1;
    assign CurrentAddressOut = addr_p1;
    assign ResultAluOut      = result_p1;

endmodule

// File: tb/tb_reg_ex_mem.sv
// ---------------------------------------------------------------------------
// tb_reg_ex_mem
//   Scoreboard bench for reg_ex_mem. The driver applies one set of inputs per
//   cycle, advances a behavioural model of the register, and queues the value
//   the outputs must show after the next rising edge. The monitor pops that
//   value at the following falling edge and compares it, then compares again
//   just before the next rising edge to confirm the outputs stayed stable.
// ---------------------------------------------------------------------------
module tb_reg_ex_mem;

    localparam int OPCODE_W = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;

    logic                clk;
    logic                rst;
    logic                stall;
    logic                flush;
    logic                valid_in;
    logic [OPCODE_W-1:0] OpCode;
    logic [ADDR_W-1:0]   CurrentAddress;
    logic [DATA_W-1:0]   ResultAlu;
    logic                valid_out;
    logic [OPCODE_W-1:0] OpCodeOut;
    logic [ADDR_W-1:0]   CurrentAddressOut;
    logic [DATA_W-1:0]   ResultAluOut;

    reg_ex_mem #(
        .OPCODE_W  (OPCODE_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_OPCODE(5'd0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .valid_in         (valid_in),
        .OpCode           (OpCode),
        .CurrentAddress   (CurrentAddress),
        .ResultAlu        (ResultAlu),
        .valid_out        (valid_out),
        .OpCodeOut        (OpCodeOut),
        .CurrentAddressOut(CurrentAddressOut),
        .ResultAluOut     (ResultAluOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string               tag;
        logic                vld;
        logic [OPCODE_W-1:0] op;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   res;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;

    // Behavioural model: what the memory stage should currently be holding.
    logic                m_vld;
    logic [OPCODE_W-1:0] m_op;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_res;

    task automatic check(input string tag, input string when, input exp_t e);
        checks++;
        if (valid_out === e.vld && OpCodeOut === e.op &&
            CurrentAddressOut === e.addr && ResultAluOut === e.res) begin
            passed++;
        end else begin
            $display("FAIL %s (%s): got vld=%b op=%0h addr=%0h res=%0h, expected vld=%b op=%0h addr=%0h res=%0h",
                     tag, when, valid_out, OpCodeOut, CurrentAddressOut, ResultAluOut,
                     e.vld, e.op, e.addr, e.res);
        end
    endtask

    // Monitor: outputs are always presented, so one expectation is consumed
    // per cycle once the driver has queued it.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, "after edge", e);
            #4;
            check(e.tag, "before next edge", e);
        end
    end

    // One cycle of stimulus: inputs change mid-cycle (after the falling edge),
    // the model takes the effect of the coming rising edge.
    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [OPCODE_W-1:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        rst            = r;
        flush          = f;
        stall          = s;
        valid_in       = v;
        OpCode         = op;
        CurrentAddress = a;
        ResultAlu      = d;
        if (r || f) begin
            m_vld  = 1'b0;
            m_op   = '0;
            m_addr = '0;
            m_res  = '0;
        end else if (!s) begin
            m_vld  = v;
            m_op   = op;
            m_addr = a;
            m_res  = d;
        end
        e.tag  = tag;
        e.vld  = m_vld;
        e.op   = m_op;
        e.addr = m_addr;
        e.res  = m_res;
        exp_q.push_back(e);
    endtask

    initial begin
        int wait_cycles;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
        OpCode = '0; CurrentAddress = '0; ResultAlu = '0;
        m_vld = 1'bx; m_op = 'x; m_addr = 'x; m_res = 'x;

        // Reset with arbitrary inputs on the bus.
        step(1, 0, 0, 1, 5'd21, 7'd99, 32'hDEADBEEF, "reset");
        step(1, 0, 1, 1, 5'd3,  7'd1,  32'd2,        "reset_with_stall");

        // Streaming.
        step(0, 0, 0, 1, 5'd3,  7'd1, 32'd2, "stream_a");
        step(0, 0, 0, 1, 5'd11, 7'd6, 32'd9, "stream_b");
        step(0, 0, 0, 1, 5'd7,  7'd9, 32'd7, "stream_c");

        // Stall for two edges, then release.
        step(0, 0, 0, 1, 5'd11, 7'd6, 32'd9, "stall_load");
        step(0, 0, 1, 1, 5'd7,  7'd9, 32'd7, "stall_1");
        step(0, 0, 1, 1, 5'd7,  7'd9, 32'd7, "stall_2");
        step(0, 0, 0, 1, 5'd7,  7'd9, 32'd7, "stall_release");

        // Flush beats stall, then the next normal edge captures.
        step(0, 0, 0, 1, 5'd3,  7'd1, 32'd2, "flush_load");
        step(0, 1, 1, 1, 5'd11, 7'd6, 32'd9, "flush_with_stall");
        step(0, 0, 0, 1, 5'd11, 7'd6, 32'd9, "after_flush");

        // Width extremes.
        step(0, 0, 0, 1, 5'h1F, 7'h7F, 32'hFFFF_FFFF, "all_ones");
        step(0, 0, 0, 1, 5'h00, 7'h00, 32'h0000_0000, "all_zeros");
        step(0, 0, 0, 1, 5'h10, 7'h40, 32'h8000_0000, "msb_only");

        // Priority and invalid capture.
        step(0, 0, 0, 1, 5'd9,  7'd33, 32'd1234, "prio_load");
        step(1, 1, 1, 1, 5'd2,  7'd2,  32'd2,    "rst_flush_stall");
        step(0, 0, 1, 1, 5'd6,  7'd6,  32'd6,    "stall_after_reset");
        step(0, 0, 0, 0, 5'd5,  7'd4,  32'd100,  "valid_in_low");
        step(0, 0, 1, 1, 5'd8,  7'd8,  32'd8,    "stall_invalid");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 12) == 0,
                 $urandom_range(0, 4) == 0, 1'($urandom),
                 OPCODE_W'($urandom), ADDR_W'($urandom), $urandom, "random");
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/reg_ex_mem.md
Name: reg_ex_mem

Overview:
EX/MEM pipeline register for the grupal pipelined processor. It captures the execute-stage results (opcode, current instruction address, ALU result) on each rising clock edge and presents them to the memory stage one cycle later. It supports pipeline stall (hold) and flush (bubble insertion), and carries a valid bit so downstream stages can ignore bubbles.

Parameters:
OPCODE_W, 5, width of the opcode field
ADDR_W, 7, width of the current instruction address field
DATA_W, 32, width of the ALU result field
NOP_OPCODE, 0, opcode value loaded on reset and flush (bubble)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  hold current contents when high
flush  input  1  load a bubble on the next edge when high
valid_in  input  1  EX-stage instruction is valid
OpCode  input  OPCODE_W  EX-stage opcode
CurrentAddress  input  ADDR_W  EX-stage instruction address
ResultAlu  input  DATA_W  EX-stage ALU result
valid_out  output  1  registered valid bit
OpCodeOut  output  OPCODE_W  registered opcode
CurrentAddressOut  output  ADDR_W  registered address
ResultAluOut  output  DATA_W  registered ALU result

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- All outputs driven directly from flops; no combinational path from any input to any output.
- Priority at each rising edge: rst > flush > stall > capture.
- rst=1: valid_out=0, OpCodeOut=NOP_OPCODE, CurrentAddressOut=0, ResultAluOut=0.
- flush=1 (rst=0): same values as reset (bubble), regardless of stall.
- stall=1 (rst=0, flush=0): all outputs hold their previous values; inputs ignored.
- Otherwise: OpCodeOut<=OpCode, CurrentAddressOut<=CurrentAddress, ResultAluOut<=ResultAlu, valid_out<=valid_in.
- Latency: exactly one clock; a value applied before edge N is visible at the outputs after edge N and stays stable until edge N+1.
- Fields are copied bit-exact; no sign extension, truncation or arithmetic.
- valid_in=0 is still captured normally: data fields are loaded and valid_out=0. Data fields are not forced to bubble values.
- Before the first reset the outputs are undefined (X in simulation). Benches must reset before checking.
- Reset or flush asserted mid-stream discards the in-flight stage contents; the next normal edge captures fresh inputs.
- rst deasserted and stall held: the registers stay at the reset/bubble values.

Test Plan:
- Reset: rst=1 for one edge with arbitrary inputs -> valid_out=0, OpCodeOut=0, CurrentAddressOut=0, ResultAluOut=0.
- Streaming (rst, stall and flush low, valid_in=1, clk period 10 ns, inputs changed between edges): (3,1,2) then (11,6,9) then (7,9,7). After each successive edge the outputs read OpCodeOut/CurrentAddressOut/ResultAluOut = 3/1/2, then 11/6/9, then 7/9/7, each with valid_out=1. Outputs never change between edges.
- Stall: load (11,6,9), then set stall=1 and inputs=(7,9,7) for 2 edges -> outputs stay 11/6/9. Release stall -> outputs 7/9/7 after the next edge.
- Flush: with outputs at 3/1/2, assert flush=1 together with stall=1 and inputs (11,6,9) -> after the edge, outputs are 0/0/0 and valid_out=0. Deassert flush -> the next edge captures the inputs.
- Width extremes: OpCode=5'h1F, CurrentAddress=7'h7F, ResultAlu=32'hFFFFFFFF, then all zeros -> outputs match bit-exact on each edge.
- Priority: assert rst and flush together with stall -> reset values. valid_in=0 with data (5,4,100) -> outputs 5/4/100 with valid_out=0.
